// File: rtl/demux_1x8_tdm.sv
// demux_1x8_tdm: time-division demultiplexer, receive side of an N:1 serializer.
// Serial bits arrive one per accepted cycle. A slot counter steers each bit into
// assembly position `slot`. When slot N-1 is filled, the word is presented on a
// valid/ready output.
//
// Ports:
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   din           serial data bit
//   din_valid     din is accepted on this rising edge
//   frame_start   qualified by din_valid; forces the current bit into slot 0
//   dout          assembled word; bit k = bit received in slot k
//   dout_valid    dout holds an unconsumed word
//   dout_ready    consumer takes dout when dout_valid && dout_ready
//   slot          slot the next accepted bit will be written to
//   overrun       one-cycle pulse when an unconsumed word was overwritten

// One assembly bit, loaded when its slot is addressed.
module demux_1x8_tdm_cell (
  input  logic clk,
  input  logic rst,
  input  logic we,
  input  logic d,
  output logic q
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= 1'b0;
    else if (we) q <= d;
  end
endmodule

module demux_1x8_tdm #(
  parameter int N     = 8,
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             frame_start,
  output logic [N-1:0]     dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [SEL_W-1:0] slot,
  output logic             overrun
);

  // Only slots 0..N-2 need storage: the last bit of a word goes straight
  // from din into dout on the completing edge.
  logic [N-2:0]     asm_q;
  logic [N-2:0]     we;
  logic [SEL_W-1:0] wr_idx;
  logic             complete;

  assign wr_idx   = frame_start ? '0 : slot;
  assign complete = din_valid && !frame_start && (slot == SEL_W'(N-1));

  generate
    for (genvar g = 0; g < N-1; g++) begin : g_slot
      assign we[g] = din_valid && (wr_idx == SEL_W'(g));
      demux_1x8_tdm_cell u_cell (
        .clk (clk),
        .rst (rst),
        .we  (we[g]),
        .d   (din),
        .q   (asm_q[g])
      );
    end
  endgenerate

  // N is a power of two, so slot+1 wraps N-1 -> 0 on its own with no dead cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      slot <= '0;
    else if (din_valid)
      slot <= frame_start ? SEL_W'(1) : slot + SEL_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      // Completing into a word nobody has taken yet is the only overrun case;
      // a same-edge handshake counts as consumed.
      overrun <= complete && dout_valid && !dout_ready;
      if (complete) begin
        dout       <= {din, asm_q};
        dout_valid <= 1'b1;
      end else if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_demux_1x8_tdm.sv
module tb_demux_1x8_tdm;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         din = 1'b0, din_valid = 1'b0, frame_start = 1'b0, dout_ready = 1'b0;
  logic [N-1:0] dout;
  logic         dout_valid, overrun;
  logic [2:0]   slot;

  int checks = 0;
  int errors = 0;

  // reference model: bits collected so far, position, output state
  int m_bits[N];
  int m_pos = 0;
  int m_dout = 0;
  int m_valid = 0;
  int m_ovr = 0;

  demux_1x8_tdm #(.N(N), .SEL_W(3)) dut (
    .clk (clk), .rst (rst), .din (din), .din_valid (din_valid),
    .frame_start (frame_start), .dout (dout), .dout_valid (dout_valid),
    .dout_ready (dout_ready), .slot (slot), .overrun (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pos = 0; m_dout = 0; m_valid = 0; m_ovr = 0;
    for (int k = 0; k < N; k++) m_bits[k] = 0;
  endtask

  task automatic model_edge(input int d, input int v, input int f, input int r);
    int done = 0;
    int w = 0;
    if (v != 0) begin
      if (f != 0) begin
        m_bits[0] = d;
        m_pos = 1;
      end else begin
        m_bits[m_pos] = d;
        if (m_pos == N-1) begin
          done = 1;
          for (int k = 0; k < N; k++) w += m_bits[k] * (1 << k);
        end
        m_pos = (m_pos + 1) % N;
      end
    end
    m_ovr = (done != 0 && m_valid != 0 && r == 0) ? 1 : 0;
    if (done != 0) begin
      m_dout = w;
      m_valid = 1;
    end else if (m_valid != 0 && r != 0) begin
      m_valid = 0;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".dout"},    32'(dout),       32'(m_dout));
    chk({tag, ".valid"},   32'(dout_valid), 32'(m_valid));
    chk({tag, ".slot"},    32'(slot),       32'(m_pos));
    chk({tag, ".overrun"}, 32'(overrun),    32'(m_ovr));
  endtask

  // One clock: inputs applied at negedge, model advanced at posedge, outputs
  // compared at the following negedge.
  task automatic step(input bit d, input bit v, input bit f, input bit r, input string tag);
    din = d; din_valid = v; frame_start = f; dout_ready = r;
    @(posedge clk);
    model_edge(int'(d), int'(v), int'(f), int'(r));
    @(negedge clk);
    check_model(tag);
  endtask

  task automatic send_word(input logic [7:0] w, input bit r, input bit fs_first, input string tag);
    for (int k = 0; k < N; k++)
      step(w[k], 1'b1, (k == 0) && fs_first, r, tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst.dout",  32'(dout), 32'h0);
    chk("rst.valid", 32'(dout_valid), 32'h0);
    chk("rst.slot",  32'(slot), 32'h0);
    chk("rst.ovr",   32'(overrun), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] pat;
    model_reset();
    repeat (2) @(negedge clk);
    do_reset();

    // 1: single word AA, valid for exactly one cycle
    send_word(8'hAA, 1'b1, 1'b0, "t1");
    chk("t1.word", 32'(dout), 32'hAA);
    chk("t1.vld", 32'(dout_valid), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1, "t1.after");
    chk("t1.vld_drop", 32'(dout_valid), 32'h0);
    chk("t1.slot0", 32'(slot), 32'h0);

    // 2: back-to-back AA then 0F
    send_word(8'hAA, 1'b1, 1'b0, "t2a");
    chk("t2.word_a", 32'(dout), 32'hAA);
    send_word(8'h0F, 1'b1, 1'b0, "t2b");
    chk("t2.word_b", 32'(dout), 32'h0F);
    chk("t2.ovr", 32'(overrun), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, "t2.after");

    // 3: overrun with ready held low
    send_word(8'hAA, 1'b0, 1'b0, "t3a");
    send_word(8'h3C, 1'b0, 1'b0, "t3b");
    chk("t3.word", 32'(dout), 32'h3C);
    chk("t3.ovr", 32'(overrun), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b0, "t3.hold");
    chk("t3.ovr_pulse", 32'(overrun), 32'h0);
    chk("t3.hold_vld", 32'(dout_valid), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1, "t3.take");
    chk("t3.vld_drop", 32'(dout_valid), 32'h0);

    // 4: partial word discarded by frame_start
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0, 1'b1, "t4.part");
    send_word(8'h81, 1'b1, 1'b1, "t4");
    chk("t4.word", 32'(dout), 32'h81);

    // 5: gaps between bits of 5A
    pat = 8'h5A;
    for (int k = 0; k < N; k++) begin
      step(pat[k], 1'b1, 1'b0, 1'b1, "t5");
      repeat (k % 3) step(1'b1, 1'b0, 1'b0, 1'b1, "t5.gap");
    end
    chk("t5.word", 32'(dout), 32'h5A);
    step(1'b0, 1'b0, 1'b0, 1'b1, "t5.after");

    // 6: reset with a pending word and a partial word in flight
    send_word(8'h77, 1'b0, 1'b0, "t6a");
    for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 1'b0, 1'b0, "t6.part");
    do_reset();
    send_word(8'hC3, 1'b1, 1'b0, "t6b");
    chk("t6.word", 32'(dout), 32'hC3);

    // random traffic against the model
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 2) != 0), "rnd");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/demux_1x8_tdm.md
Name: demux_1x8_tdm

Overview:
Time-division demultiplexer. It is the receive end of the 8:1 mux serializer.
- A serial bit stream arrives one bit per accepted cycle.
- A slot counter plays the role of the mux select and routes each bit into register position dout[slot].
- After N slots, the assembled word is presented on a valid/ready output port.
- The block sits between a serial link and the parallel consumer logic.

Parameters:
N, 8, number of slots and output word width; must be a power of 2, N >= 2
SEL_W, 3, slot counter width, equal to log2(N)

Ports:
clk  input  1  system clock, rising edge active
rst  input  1  asynchronous, active-high reset
din  input  1  serial data bit
din_valid  input  1  din is valid this cycle; bit is accepted on the rising clk edge
frame_start  input  1  qualified by din_valid; marks the current bit as slot 0
dout  output  N  assembled word; bit k = bit received in slot k
dout_valid  output  1  dout holds an unconsumed word
dout_ready  input  1  consumer accepts dout when dout_valid && dout_ready
slot  output  SEL_W  slot index the next accepted bit will be written to
overrun  output  1  one-cycle pulse: an unconsumed word was overwritten

Behaviour:
- Reset (asynchronous on rst=1, all values held while rst=1):
  - slot=0, assembly register=0, dout=0, dout_valid=0, overrun=0.
- Cycles with din_valid=0: no state change on the input side; slot holds.
- Accept with frame_start=1 (takes priority over the slot count):
  - asm[0] <= din; slot <= 1.
  - Any partial word already in progress is discarded and produces no output.
- Accept with frame_start=0:
  - asm[slot] <= din.
  - If slot != N-1: slot <= slot+1.
  - If slot == N-1: slot <= 0 (wrap) and the word completes.
- Word completion:
  - On the completing edge: dout <= asm with bit N-1 replaced by the current din; dout_valid <= 1.
  - Latency: dout_valid is high in the cycle after the Nth bit is accepted.
  - With N=8, the bit accepted in slot k lands in dout[k]. This matches the serializer driving sel=k to output a[k].
- Output handshake:
  - dout and dout_valid are stable while dout_valid=1 and dout_ready=0.
  - dout_valid=1 && dout_ready=1 with no completion on the same edge: dout_valid <= 0; dout retains its last value.
  - Completion on the same edge as a handshake: the new word loads, dout_valid stays 1, overrun=0.
  - Completion while dout_valid=1 && dout_ready=0: the new word overwrites dout, dout_valid stays 1, overrun=1 for exactly one cycle.
- Slot counter:
  - Advances only on accepted bits.
  - Wraps N-1 -> 0 with no dead cycle, so back-to-back words stream with no gap.
- Mid-operation reset: any partial word and any pending dout are lost; all outputs return to reset values immediately.
- The first word after reset does not require frame_start. Slot 0 is implied by the reset value of slot.
- The assembly register is not cleared between words. Every position is rewritten before completion.
- All outputs are registered; there is no combinational path from din or dout_ready to any output.

Test Plan:
1. Reset, then din_valid=1 for 8 cycles with din = 0,1,0,1,0,1,0,1 (sel 0..7 order of a=8'b10101010), dout_ready=1 -> dout=8'hAA and dout_valid=1 for exactly one cycle, in the cycle after the 8th bit; slot reads 0 afterwards.
2. Stream 16 bits back-to-back for the words 8'hAA then 8'h0F, dout_ready=1 -> dout_valid pulses twice, 8 cycles apart, carrying AA then 0F; overrun stays 0.
3. Hold dout_ready=0 after the first word, then send a second word 8'h3C -> dout=3C, dout_valid=1, overrun=1 for one cycle on the completion edge; raising dout_ready then drops dout_valid on the next edge.
4. Send 3 bits, then assert frame_start with 8 further bits forming 8'h81 -> the partial word is discarded; a single output 8'h81 is produced.
5. Insert din_valid=0 gaps between bits of 8'h5A -> slot holds during the gaps; output is 8'h5A; latency is measured from the last accepted bit only.
6. Assert rst after 5 bits while an earlier word is pending -> slot=0, dout=0, dout_valid=0 immediately; 8 new bits for 8'hC3 yield dout=8'hC3.
